// File: rtl/importance_ctrl_pkg.sv
// importance_ctrl_pkg
// Shared types and constants for the importance controller and its row-minimum
// tracker: FSM state encoding, datapath/address/dimension widths and the
// tracker reload value.
package importance_ctrl_pkg;

  localparam int DATA_W = 18;  // 2.16 importance / pixel component width
  localparam int ADDR_W = 20;  // linear pixel address width
  localparam int DIM_W  = 10;  // frame width/height width (max 1023)

  localparam logic [DATA_W-1:0] ROWMIN_INIT = 18'h3FFFF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_LATCH = 3'd2,
    S_WR    = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/importance_ctrl_rowmin.sv
// importance_rowmin
// Per-row unsigned minimum tracker over the accepted importance writes.
// Ties keep the earliest (lowest) column. When the last column of a row is
// accepted, the row's result is reported for one cycle and tracking reloads.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_clear           reload tracker (frame start accepted)
//   i_wr_acc          a write was accepted this cycle
//   i_wr_data         accepted write data
//   i_col             column of the accepted write
//   i_last_col        accepted write is the last column of its row
//   o_valid           one-cycle row result strobe
//   o_min, o_min_col  row minimum value and its column
module importance_rowmin
  import importance_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_wr_acc,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [DIM_W-1:0]  i_col,
  input  logic              i_last_col,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_min,
  output logic [DIM_W-1:0]  o_min_col
);

  logic [DATA_W-1:0] r_min;
  logic [DIM_W-1:0]  r_min_col;
  logic              r_valid;
  logic [DATA_W-1:0] r_out_min;
  logic [DIM_W-1:0]  r_out_col;

  logic              w_take;
  logic [DATA_W-1:0] w_min;
  logic [DIM_W-1:0]  w_min_col;

  // Strict less-than keeps the earlier column on a tie.
  always_comb begin
    w_take    = (i_wr_data < r_min);
    w_min     = w_take ? i_wr_data : r_min;
    w_min_col = w_take ? i_col : r_min_col;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_min     <= ROWMIN_INIT;
      r_min_col <= '0;
      r_valid   <= 1'b0;
      r_out_min <= '0;
      r_out_col <= '0;
    end else begin
      r_valid <= 1'b0;
      if (i_clear) begin
        r_min     <= ROWMIN_INIT;
        r_min_col <= '0;
      end else if (i_wr_acc) begin
        if (i_last_col) begin
          r_out_min <= w_min;
          r_out_col <= w_min_col;
          r_valid   <= 1'b1;
          r_min     <= ROWMIN_INIT;
          r_min_col <= '0;
        end else begin
          r_min     <= w_min;
          r_min_col <= w_min_col;
        end
      end
    end
  end

  assign o_valid   = r_valid;
  assign o_min     = r_out_min;
  assign o_min_col = r_out_col;

endmodule

// File: rtl/importance_ctrl.sv
// importance_ctrl
// Frame sequencer for the importance map: for every pixel it reads saturation
// and luminance from pixel memory, presents them (with the frame bias) to the
// external importance datapath, and writes the combinational result to the
// importance buffer with a ready handshake. 3 cycles per pixel (RD, LATCH, WR)
// plus one cycle per wr_ready stall.
// Optional feature: define IMPORTANCE_ROWMIN_EN to build the per-row minimum
// reporter; otherwise row_min_valid/row_min/row_min_col are tied to 0.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, width, height,      frame request and parameters (sampled in IDLE)
//   constant
//   rd_en, rd_addr             pixel memory read strobe / address
//   rd_sat, rd_lum             pixel data, valid one cycle after rd_en
//   imp_sat, imp_lum,          registered datapath operands
//   imp_const
//   imp_result                 datapath result (combinational)
//   wr_en, wr_addr, wr_data,   importance buffer write with handshake
//   wr_ready
//   busy, done                 frame status / completion pulse
//   row_min_valid, row_min,    per-row minimum report (optional)
//   row_min_col
module importance_ctrl
  import importance_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  input  logic [DATA_W-1:0] constant,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_sat,
  input  logic [DATA_W-1:0] rd_lum,
  output logic [DATA_W-1:0] imp_sat,
  output logic [DATA_W-1:0] imp_lum,
  output logic [DATA_W-1:0] imp_const,
  input  logic [DATA_W-1:0] imp_result,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic              row_min_valid,
  output logic [DATA_W-1:0] row_min,
  output logic [DIM_W-1:0]  row_min_col
);

  state_t            r_state;
  logic [DIM_W-1:0]  r_width;
  logic [DIM_W-1:0]  r_height;
  logic [DIM_W-1:0]  r_col;
  logic [DIM_W-1:0]  r_row;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rd_en;
  logic              r_wr_en;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] r_imp_sat;
  logic [DATA_W-1:0] r_imp_lum;
  logic [DATA_W-1:0] r_imp_const;

  logic w_accept;
  logic w_last_col;
  logic w_last_pix;

  // r_wr_en is only ever set while in WR, so it doubles as the state qualifier.
  assign w_accept   = r_wr_en & wr_ready;
  assign w_last_col = (r_col == (r_width - 10'd1));
  assign w_last_pix = w_last_col & (r_row == (r_height - 10'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_width     <= '0;
      r_height    <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_addr      <= '0;
      r_rd_en     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_imp_sat   <= '0;
      r_imp_lum   <= '0;
      r_imp_const <= '0;
    end else begin
      r_rd_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_width     <= width;
            r_height    <= height;
            r_imp_const <= constant;
            r_col       <= '0;
            r_row       <= '0;
            r_addr      <= '0;
            r_busy      <= 1'b1;
            if ((width == '0) || (height == '0)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RD;
              r_rd_en <= 1'b1;
            end
          end
        end
        S_RD: begin
          r_state <= S_LATCH;
        end
        S_LATCH: begin
          r_imp_sat <= rd_sat;
          r_imp_lum <= rd_lum;
          r_wr_en   <= 1'b1;
          r_state   <= S_WR;
        end
        S_WR: begin
          if (wr_ready) begin
            r_wr_en <= 1'b0;
            if (w_last_pix) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              // Linear address advances by one; no row*width product needed.
              r_addr <= r_addr + 20'd1;
              if (w_last_col) begin
                r_col <= '0;
                r_row <= r_row + 10'd1;
              end else begin
                r_col <= r_col + 10'd1;
              end
              r_state <= S_RD;
              r_rd_en <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_wr_en <= 1'b0;
        end
      endcase
    end
  end

  assign rd_en     = r_rd_en;
  assign rd_addr   = r_addr;
  assign wr_en     = r_wr_en;
  assign wr_addr   = r_addr;
  // Operands are frozen during WR, so the datapath result is stable while stalled.
  assign wr_data   = r_wr_en ? imp_result : '0;
  assign imp_sat   = r_imp_sat;
  assign imp_lum   = r_imp_lum;
  assign imp_const = r_imp_const;
  assign busy      = r_busy;
  assign done      = r_done;

`ifdef IMPORTANCE_ROWMIN_EN
  logic w_start_acc;
  assign w_start_acc = (r_state == S_IDLE) & start;

  importance_rowmin u_rowmin (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_start_acc),
    .i_wr_acc   (w_accept),
    .i_wr_data  (wr_data),
    .i_col      (r_col),
    .i_last_col (w_last_col),
    .o_valid    (row_min_valid),
    .o_min      (row_min),
    .o_min_col  (row_min_col)
  );
`else
  assign row_min_valid = 1'b0;
  assign row_min       = '0;
  assign row_min_col   = '0;
`endif

endmodule

// File: tb/tb_importance_ctrl.sv
// tb_importance_ctrl
// Scoreboard bench for importance_ctrl: expected writes are queued when a frame
// is launched and a monitor pops/compares on every accepted write. Pixel memory
// and the importance datapath are modelled in the bench.
module tb_importance_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [9:0]  width;
  logic [9:0]  height;
  logic [17:0] constant;
  logic        rd_en;
  logic [19:0] rd_addr;
  logic [17:0] rd_sat;
  logic [17:0] rd_lum;
  logic [17:0] imp_sat;
  logic [17:0] imp_lum;
  logic [17:0] imp_const;
  logic [17:0] imp_result;
  logic        wr_en;
  logic [19:0] wr_addr;
  logic [17:0] wr_data;
  logic        wr_ready;
  logic        busy;
  logic        done;
  logic        row_min_valid;
  logic [17:0] row_min;
  logic [9:0]  row_min_col;

  importance_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .width         (width),
    .height        (height),
    .constant      (constant),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_sat        (rd_sat),
    .rd_lum        (rd_lum),
    .imp_sat       (imp_sat),
    .imp_lum       (imp_lum),
    .imp_const     (imp_const),
    .imp_result    (imp_result),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .busy          (busy),
    .done          (done),
    .row_min_valid (row_min_valid),
    .row_min       (row_min),
    .row_min_col   (row_min_col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [19:0] addr;
    logic [17:0] data;
  } wr_t;

  typedef struct packed {
    logic [17:0] val;
    logic [9:0]  col;
  } rm_t;

  wr_t exp_q[$];
  rm_t rm_q[$];
  int  checks = 0;
  int  errors = 0;
  int  wr_cnt = 0;
  int  rd_cnt = 0;
  int  done_cnt = 0;
  bit  rm_bad = 1'b0;
  bit  tbl_mode = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] sat_of(input logic [19:0] a);
    if (tbl_mode) begin
      case (a[1:0])
        2'd0:    return 18'd9;
        2'd1:    return 18'd3;
        2'd2:    return 18'd7;
        default: return 18'd3;
      endcase
    end
    return 18'(a * 7 + 3);
  endfunction

  function automatic logic [17:0] lum_of(input logic [19:0] a);
    if (tbl_mode) return 18'd0;
    return 18'(a * 11 + 5);
  endfunction

  function automatic logic [17:0] imp_exp(input logic [19:0] a, input logic [17:0] c);
    return 18'(sat_of(a) + (lum_of(a) >> 1) + c);
  endfunction

  // Pixel memory: data valid the cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_sat <= sat_of(rd_addr);
      rd_lum <= lum_of(rd_addr);
    end
  end

  // Importance datapath model.
  assign imp_result = 18'(imp_sat + (imp_lum >> 1) + imp_const);

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en && wr_ready) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(wr_addr), 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(e.addr));
          chk("wr_data", 32'(wr_data), 32'(e.data));
        end
      end
      if (rd_en) rd_cnt++;
      if (done) done_cnt++;
      if (row_min_valid) rm_q.push_back('{val: row_min, col: row_min_col});
      if (row_min_valid || (row_min != '0) || (row_min_col != '0)) rm_bad = 1'b1;
    end
  end

  task automatic run_frame(input logic [9:0] w, input logic [9:0] h, input logic [17:0] c,
                           input int stall_pix, input int stall_len, input bit restart,
                           input int exp_cyc);
    int cyc;
    int sc;
    int wr0;
    int rd0;
    int dn0;
    for (int r = 0; r < int'(h); r++)
      for (int k = 0; k < int'(w); k++)
        exp_q.push_back('{addr: 20'(r * int'(w) + k), data: imp_exp(20'(r * int'(w) + k), c)});
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    dn0 = done_cnt;
    width = w;
    height = h;
    constant = c;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    cyc = 0;
    sc = 0;
    while (!done && cyc < 2000) begin
      if (wr_en && (int'(wr_addr) == stall_pix) && sc < stall_len) begin
        wr_ready = 1'b0;
        chk("stall_wr_data", 32'(wr_data), 32'(imp_exp(20'(stall_pix), c)));
        sc++;
      end else begin
        wr_ready = 1'b1;
      end
      if (restart && cyc == 4) begin
        start = 1'b1;
        width = 10'd2;
        height = 10'd1;
        constant = 18'h155;
      end else if (restart && cyc == 5) begin
        start = 1'b0;
        width = w;
        height = h;
        constant = c;
      end
      @(posedge clk); #1;
      cyc++;
    end
    wr_ready = 1'b1;
    chk("frame_latency", 32'(cyc), 32'(exp_cyc));
    chk("busy_in_done", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_cleared", 32'(busy), 32'd0);
    chk("write_count", 32'(wr_cnt - wr0), 32'(int'(w) * int'(h)));
    chk("read_count", 32'(rd_cnt - rd0), 32'(int'(w) * int'(h)));
    chk("done_count", 32'(done_cnt - dn0), 32'd1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int n;
    int dn0;
    rst_n = 1'b0;
    start = 1'b0;
    width = '0;
    height = '0;
    constant = '0;
    wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(wr_addr), 32'd0);
    chk("rst_imp", 32'(imp_sat | imp_lum | imp_const), 32'd0);
    chk("rst_rowmin", {13'd0, row_min_valid, row_min}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic 4x2 frame.
    run_frame(10'd4, 10'd2, 18'h00100, -1, 0, 1'b0, 24);
    // Zero width: straight to DONE, no traffic.
    run_frame(10'd0, 10'd5, 18'h00007, -1, 0, 1'b0, 0);
    // Five stall cycles on pixel 3.
    run_frame(10'd4, 10'd2, 18'h00020, 3, 5, 1'b0, 29);

    // Asynchronous reset while pixel 2 is waiting in WR.
    exp_q.push_back('{addr: 20'd0, data: imp_exp(20'd0, 18'd5)});
    exp_q.push_back('{addr: 20'd1, data: imp_exp(20'd1, 18'd5)});
    dn0 = done_cnt;
    width = 10'd4;
    height = 10'd2;
    constant = 18'd5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(wr_en && wr_addr == 20'd2) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_pix2_wr", 32'(wr_en && wr_addr == 20'd2), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_wr_en", 32'(wr_en), 32'd0);
    chk("arst_rd_en", 32'(rd_en), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_addr", 32'(wr_addr | rd_addr), 32'd0);
    chk("arst_wr_data", 32'(wr_data), 32'd0);
    chk("arst_imp", 32'(imp_sat | imp_lum | imp_const), 32'd0);
    chk("arst_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    chk("arst_no_done", 32'(done_cnt - dn0), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(10'd4, 10'd2, 18'h00011, -1, 0, 1'b0, 24);

    // start re-asserted mid-frame with other dimensions is ignored.
    run_frame(10'd3, 10'd2, 18'h00003, -1, 0, 1'b1, 18);

    // Row results {9,3,7,3}.
    tbl_mode = 1'b1;
    rm_q.delete();
    rm_bad = 1'b0;
    run_frame(10'd4, 10'd1, 18'd0, -1, 0, 1'b0, 12);
`ifdef IMPORTANCE_ROWMIN_EN
    chk("rowmin_pulses", 32'(rm_q.size()), 32'd1);
    if (rm_q.size() > 0) begin
      chk("rowmin_val", 32'(rm_q[0].val), 32'd3);
      chk("rowmin_col", 32'(rm_q[0].col), 32'd1);
    end
`else
    chk("rowmin_tied_off", 32'(rm_bad), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
